// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: funct codes,
// FSM state encoding and the datapath step mode.
package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: add-shift-right for multiply,
// compare-subtract-shift-left (restoring) for divide. acc is {upper, lower}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  step_mode_e         mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, opnd_i});
        // When ge holds the true difference is below opnd_i, so the low bits suffice
        diff   = rem_sh[WIDTH-1:0] - opnd_i;
        if (mode_i == MODE_DIV) begin
            acc_o = ge ? {diff, acc_i[WIDTH-2:0], 1'b1}
                       : {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer with HI/LO registers and EX-stage stall.
// Define SIGNED_MULDIV_EN to also decode MULT/DIV (sign-magnitude wrapper).
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_rtype,
    input  logic [5:0]       ex_funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_rdata
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    logic               is_r, mul_op, div_op, mfr_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               sgn_res, sgn_rem;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;
    step_mode_e         step_mode;

    always_comb begin
        is_r    = ex_valid & ex_rtype;
        mul_op  = is_r & (ex_funct == FN_MULTU);
        div_op  = is_r & (ex_funct == FN_DIVU);
        mfr_op  = is_r & ((ex_funct == FN_MFHI) | (ex_funct == FN_MFLO));
        a_mag   = op_a;
        b_mag   = op_b;
        sgn_res = 1'b0;
        sgn_rem = 1'b0;
`ifdef SIGNED_MULDIV_EN
        if (is_r & ((ex_funct == FN_MULT) | (ex_funct == FN_DIV))) begin
            mul_op  = (ex_funct == FN_MULT);
            div_op  = (ex_funct == FN_DIV);
            a_mag   = op_a[WIDTH-1] ? -op_a : op_a;
            b_mag   = op_b[WIDTH-1] ? -op_b : op_b;
            sgn_res = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            sgn_rem = op_a[WIDTH-1];
        end
`endif
    end

    assign step_mode = (state_q == ST_DIV) ? MODE_DIV : MODE_MUL;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (step_mode),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        prod      = neg_res_q ? -step_acc : step_acc;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if ((mul_op | div_op) & !stall) begin
                    // Multiply and divide share one initial image: {0, op_a}
                    state_d   = mul_op ? ST_MUL : ST_DIV;
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    opnd_d    = b_mag;
                    cnt_d     = '0;
                    neg_res_d = sgn_res;
                    neg_rem_d = sgn_rem;
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    if (state_q == ST_MUL) begin
                        {hi_d, lo_d} = prod;
                    end else begin
                        hi_d = neg_rem_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
                        lo_d = neg_res_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_MUL) | (state_q == ST_DIV);
        done       = (state_q == ST_DONE);
        stall      = busy & (mul_op | div_op | mfr_op);
        hi         = hi_q;
        lo         = lo_q;
        hilo_rdata = (ex_funct == FN_MFHI) ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed self-checking bench for muldiv_hilo_ctrl (WIDTH = 32).
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_rtype;
    logic [5:0]  ex_funct;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] hi, lo, hilo_rdata;

    int checks = 0;
    int errors = 0;
    int cyc, bcnt, scnt;

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_rtype   (ex_rtype),
        .ex_funct   (ex_funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .hilo_rdata (hilo_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1;
        ex_rtype = 1'b1;
        ex_funct = fn;
        op_a     = a;
        op_b     = b;
        step();
        // Scribble the operands to show they are only sampled at issue
        ex_valid = 1'b0;
        ex_funct = 6'h00;
        op_a     = 32'hDEADBEEF;
        op_b     = 32'h0BADF00D;
        #1;
    endtask

    // Counts edges from issue to the DONE state, and busy/stall samples on the way
    task automatic run_to_done(output int c, output int b, output int s);
        c = 0;
        b = 0;
        s = 0;
        while (done !== 1'b1 && c < 40) begin
            if (busy === 1'b1) b++;
            if (stall === 1'b1) s++;
            step();
            c++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        ex_valid = 1'b0;
        ex_rtype = 1'b0;
        ex_funct = 6'h00;
        op_a     = '0;
        op_b     = '0;
        step();
        step();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;

        // MULTU max * max
        issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mul1_busy_after_issue", {31'b0, busy}, 32'd1);
        run_to_done(cyc, bcnt, scnt);
        check("mul1_latency", cyc, 32'd32);
        check("mul1_hi", hi, 32'hFFFFFFFE);
        check("mul1_lo", lo, 32'h00000001);
        step();
        check("mul1_done_single", {31'b0, done}, 32'd0);

        // DIVU 100/7 with an unrelated ADD sitting in EX (must not stall)
        issue(6'h1B, 32'd100, 32'd7);
        ex_valid = 1'b1;
        ex_funct = 6'h20;
        #1;
        run_to_done(cyc, bcnt, scnt);
        check("div1_latency", cyc, 32'd32);
        check("div1_busy_cycles", bcnt, 32'd32);
        check("div1_unrelated_nostall", scnt, 32'd0);
        check("div1_lo", lo, 32'd14);
        check("div1_hi", hi, 32'd2);
        ex_valid = 1'b0;
        step();

        // MULTU 6*7 then MFHI held in EX, then MFLO
        issue(6'h19, 32'd6, 32'd7);
        ex_valid = 1'b1;
        ex_funct = 6'h10;
        #1;
        run_to_done(cyc, bcnt, scnt);
        check("mfhi_stall_cycles", scnt, 32'd32);
        check("mfhi_done_stall", {31'b0, stall}, 32'd0);
        check("mfhi_rdata", hilo_rdata, 32'd0);
        step();
        ex_funct = 6'h12;
        #1;
        check("mflo_stall", {31'b0, stall}, 32'd0);
        check("mflo_rdata", hilo_rdata, 32'd42);
        ex_valid = 1'b0;
        step();

        // DIVU 5/0: natural restoring result
        issue(6'h1B, 32'd5, 32'd0);
        run_to_done(cyc, bcnt, scnt);
        check("div0_latency", cyc, 32'd32);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'h00000005);
        step();
        check("div0_done_single", {31'b0, done}, 32'd0);
        check("div0_idle", {31'b0, busy}, 32'd0);

        // Back-to-back: DIVU held in EX behind MULTU, accepted in the DONE cycle
        issue(6'h19, 32'd2, 32'd3);
        ex_valid = 1'b1;
        ex_funct = 6'h1B;
        op_a     = 32'd50;
        op_b     = 32'd7;
        #1;
        run_to_done(cyc, bcnt, scnt);
        check("b2b_mul_stall_cycles", scnt, 32'd32);
        check("b2b_mul_lo", lo, 32'd6);
        check("b2b_mul_hi", hi, 32'd0);
        check("b2b_done_nostall", {31'b0, stall}, 32'd0);
        step();
        ex_valid = 1'b0;
        #1;
        check("b2b_div_busy", {31'b0, busy}, 32'd1);
        run_to_done(cyc, bcnt, scnt);
        check("b2b_div_latency", cyc, 32'd32);
        check("b2b_div_lo", lo, 32'd7);
        check("b2b_div_hi", hi, 32'd1);
        step();

        // Reset during iteration 10 of MULTU 9*9
        issue(6'h19, 32'd9, 32'd9);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        step();
        check("rst_mid_stays_idle", {31'b0, done}, 32'd0);
        issue(6'h19, 32'd3, 32'd4);
        run_to_done(cyc, bcnt, scnt);
        check("post_rst_latency", cyc, 32'd32);
        check("post_rst_lo", lo, 32'd12);
        check("post_rst_hi", hi, 32'd0);
        step();

        // MULT -2*3
        issue(6'h18, 32'hFFFFFFFE, 32'd3);
`ifdef SIGNED_MULDIV_EN
        check("mult_busy", {31'b0, busy}, 32'd1);
        run_to_done(cyc, bcnt, scnt);
        check("mult_latency", cyc, 32'd32);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
`else
        check("mult_ignored_busy", {31'b0, busy}, 32'd0);
        ex_valid = 1'b1;
        ex_funct = 6'h18;
        #1;
        check("mult_ignored_stall", {31'b0, stall}, 32'd0);
        repeat (3) step();
        check("mult_ignored_busy_later", {31'b0, busy}, 32'd0);
        check("mult_ignored_hi", hi, 32'd0);
        check("mult_ignored_lo", lo, 32'd12);
        ex_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
